// File: rtl/jtpang_objdma.sv
// Pang object DMA: takes the Z80 bus, copies object attributes from the upper
// VRAM bank into the object line buffer, then flips the double-buffer select.
module jtpang_objdma #(
    parameter int          LEN      = 512,
    parameter logic [11:0] SRC_BASE = 12'h000,
    parameter int          AW       = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          busak_n,
    output logic          busrq_n,
    output logic [11:0]   vram_addr,
    output logic          vram_cs,
    output logic          vram_msb,
    input  logic [7:0]    vram_dout,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          buf_we,
    output logic          buf_sel,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        COPY  = 3'd2,
        FLUSH = 3'd3,
        REL   = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    state_t        state_q, state_d;
    logic          go_q;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          busrq_q, busrq_d;
    logic          cs_q, cs_d;
    logic [11:0]   vaddr_q, vaddr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [7:0]    bdin_q, bdin_d;
    logic          sel_q, sel_d;
    logic          go_edge;

    assign go_edge = dma_go & ~go_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | go_edge;
        busy_d  = busy_q;
        busrq_d = busrq_q;
        cs_d    = 1'b0;
        vaddr_d = vaddr_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        baddr_d = baddr_q;
        bdin_d  = bdin_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d  = go_edge;
                    state_d = REQ;
                    busy_d  = 1'b1;
                    busrq_d = 1'b0;
                end
            end
            REQ: begin
                if (cen && !busak_n) begin
                    state_d = COPY;
                    cs_d    = 1'b1;
                    vaddr_d = SRC_BASE;
                    idx_d   = '0;
                end
            end
            COPY: begin
                // write back the byte addressed last clock while issuing the next
                we_d    = 1'b1;
                baddr_d = idx_q;
                bdin_d  = vram_dout;
                if (idx_q == LAST) begin
                    state_d = FLUSH;
                end else begin
                    cs_d    = 1'b1;
                    vaddr_d = vaddr_q + 12'd1;
                    idx_d   = idx_q + AW'(1);
                end
            end
            FLUSH: begin
                sel_d   = ~sel_q;
                busrq_d = 1'b1;
                state_d = REL;
            end
            REL: begin
                if (cen && busak_n) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            busrq_q <= 1'b1;
            cs_q    <= 1'b0;
            vaddr_q <= SRC_BASE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            baddr_q <= '0;
            bdin_q  <= 8'h00;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= dma_go;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            busrq_q <= busrq_d;
            cs_q    <= cs_d;
            vaddr_q <= vaddr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            bdin_q  <= bdin_d;
            sel_q   <= sel_d;
        end
    end

    assign busrq_n   = busrq_q;
    assign vram_addr = vaddr_q;
    assign vram_cs   = cs_q;
    assign vram_msb  = cs_q;
    assign buf_addr  = baddr_q;
    assign buf_din   = bdin_q;
    assign buf_we    = we_q;
    assign buf_sel   = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Scoreboard bench for jtpang_objdma: expected buffer writes and VRAM
// addresses are queued per triggered transfer and popped as the DUT emits them.
module tb_jtpang_objdma;

    localparam int          LEN = 512;
    localparam int          AW  = 9;
    localparam logic [11:0] SRC = 12'hF00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cen = 1'b0;
    logic          dma_go;
    logic          busak_n;
    logic          busrq_n;
    logic [11:0]   vram_addr;
    logic          vram_cs;
    logic          vram_msb;
    logic [7:0]    vram_dout;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_din;
    logic          buf_we;
    logic          buf_sel;
    logic          busy;

    logic [7:0]      mem [4096];
    logic [AW+7:0]   wr_q [$];
    logic [11:0]     va_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int flips = 0;
    int strobe_bad = 0;
    int msb_bad = 0;
    int cs_first = -1;
    int ack_fall = 0;
    int rq_fall = 0;
    int ack_dly = 3;
    int lo_cnt = 0;
    int hi_cnt = 0;

    jtpang_objdma #(.LEN(LEN), .SRC_BASE(SRC), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .dma_go   (dma_go),
        .busak_n  (busak_n),
        .busrq_n  (busrq_n),
        .vram_addr(vram_addr),
        .vram_cs  (vram_cs),
        .vram_msb (vram_msb),
        .vram_dout(vram_dout),
        .buf_addr (buf_addr),
        .buf_din  (buf_din),
        .buf_we   (buf_we),
        .buf_sel  (buf_sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign vram_dout = mem[vram_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // CPU clock enable and a Z80 that acknowledges after a few cen cycles
    initial forever begin
        @(posedge clk);
        cen <= ~cen;
        if (cen) begin
            if (!busrq_n) begin
                hi_cnt = 0;
                if (lo_cnt >= ack_dly) busak_n <= 1'b0;
                else lo_cnt++;
            end else begin
                lo_cnt = 0;
                if (hi_cnt >= 2) busak_n <= 1'b1;
                else hi_cnt++;
            end
        end
    end

    initial begin
        logic [AW+7:0] e;
        logic [11:0]   a;
        logic          sel_p = 1'b0;
        logic          ak_p  = 1'b1;
        logic          rq_p  = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (buf_we) begin
                    wr_cnt++;
                    if (wr_q.size() == 0) chk("spurious_we", 1, 0);
                    else begin
                        e = wr_q.pop_front();
                        chk("buf_wr", {buf_addr, buf_din}, e);
                    end
                end
                if (vram_cs) begin
                    if (cs_first < 0) cs_first = cyc;
                    if (va_q.size() == 0) chk("spurious_cs", 1, 0);
                    else begin
                        a = va_q.pop_front();
                        chk("vram_addr", vram_addr, a);
                    end
                end
                if ((vram_cs || buf_we) && (busrq_n || busak_n)) strobe_bad++;
                if (vram_msb !== vram_cs) msb_bad++;
            end
            if (buf_sel !== sel_p) flips++;
            if (ak_p && !busak_n) ack_fall = cyc;
            if (rq_p && !busrq_n) rq_fall = cyc;
            sel_p = buf_sel;
            ak_p  = busak_n;
            rq_p  = busrq_n;
        end
    end

    task automatic fill(input logic [7:0] pat);
        for (int i = 0; i < LEN; i++)
            mem[SRC + 12'(i)] = 8'(i) ^ pat;
    endtask

    task automatic push_xfer(input logic [7:0] pat);
        for (int i = 0; i < LEN; i++) begin
            wr_q.push_back({AW'(i), 8'(i) ^ pat});
            va_q.push_back(SRC + 12'(i));
        end
    endtask

    task automatic pulse(input int n);
        @(negedge clk);
        dma_go = 1'b1;
        repeat (n) @(negedge clk);
        dma_go = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, lvl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int f0, w0, n;
        rst_n   = 1'b0;
        dma_go  = 1'b0;
        busak_n = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_busrq_n", busrq_n, 1);
        chk("rst_vram_cs", vram_cs, 0);
        chk("rst_vram_msb", vram_msb, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_buf_din", buf_din, 0);
        chk("rst_vram_addr", vram_addr, SRC);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // basic copy with source wrap F00..FFF, 000..0FF
        fill(8'h5A);
        push_xfer(8'h5A);
        pulse(4);
        wait_busy(1, 50, "t1_busy_rise");
        wait_busy(0, 3000, "t1_busy_fall");
        chk("t1_buf_sel", buf_sel, 1);
        chk("t1_busrq_n", busrq_n, 1);
        chk("t1_busak_n", busak_n, 1);
        chk("t1_wr_left", wr_q.size(), 0);
        chk("t1_va_left", va_q.size(), 0);
        chk("t1_wr_cnt", wr_cnt, LEN);
        chk("t1_flips", flips, 1);

        // held trigger
        fill(8'hA5);
        push_xfer(8'hA5);
        f0 = flips;
        @(negedge clk);
        dma_go = 1'b1;
        repeat (2000) @(negedge clk);
        dma_go = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_flips", flips - f0, 1);
        chk("t2_buf_sel", buf_sel, 0);
        chk("t2_busy", busy, 0);
        chk("t2_wr_left", wr_q.size(), 0);

        // re-trigger twice during COPY -> exactly two transfers
        fill(8'h3C);
        push_xfer(8'h3C);
        push_xfer(8'h3C);
        f0 = flips;
        pulse(2);
        n = 0;
        while (!vram_cs && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3_copy_start", vram_cs, 1);
        repeat (10) @(negedge clk);
        pulse(2);
        repeat (100) @(negedge clk);
        pulse(2);
        wait_busy(0, 3000, "t3_first_done");
        wait_busy(1, 50, "t3_second_start");
        wait_busy(0, 3000, "t3_second_done");
        repeat (20) @(negedge clk);
        chk("t3_flips", flips - f0, 2);
        chk("t3_buf_sel", buf_sel, 0);
        chk("t3_busy", busy, 0);
        chk("t3_wr_left", wr_q.size(), 0);

        // delayed acknowledge
        ack_dly = 100;
        fill(8'hC3);
        push_xfer(8'hC3);
        cs_first = -1;
        pulse(2);
        wait_busy(1, 50, "t4_busy_rise");
        wait_busy(0, 3000, "t4_busy_fall");
        chk("t4_ack_to_cs", cs_first - ack_fall, 2);
        chk("t4_ack_wait", (ack_fall - rq_fall) > 190, 1);
        chk("t4_strobe_bad", strobe_bad, 0);
        chk("t4_wr_left", wr_q.size(), 0);
        chk("t4_buf_sel", buf_sel, 1);
        ack_dly = 3;

        // async reset at byte 200
        fill(8'h96);
        push_xfer(8'h96);
        w0 = wr_cnt;
        pulse(2);
        n = 0;
        while (wr_cnt != w0 + 200 && n < 2000) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("t5_reached_200", wr_cnt - w0, 200);
        rst_n = 1'b0;
        #1;
        chk("t5_busrq_n", busrq_n, 1);
        chk("t5_buf_we", buf_we, 0);
        chk("t5_vram_cs", vram_cs, 0);
        chk("t5_busy", busy, 0);
        chk("t5_buf_sel", buf_sel, 0);
        chk("t5_wr_left", wr_q.size(), LEN - 200);
        wr_q.delete();
        va_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("t5_no_writes", wr_cnt - w0, 200);
        chk("t5_idle", busy, 0);
        chk("t5_sel_hold", buf_sel, 0);

        fill(8'h0F);
        push_xfer(8'h0F);
        pulse(2);
        wait_busy(1, 50, "t5_busy_rise");
        wait_busy(0, 3000, "t5_busy_fall");
        chk("t5_recover_sel", buf_sel, 1);
        chk("t5_recover_left", wr_q.size(), 0);

        chk("strobe_bad", strobe_bad, 0);
        chk("msb_bad", msb_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtpang_objdma.md
Name: jtpang_objdma

Overview:
- Sequences the object (sprite) DMA for the Pang main board.
- On a CPU I/O write to port 6 (dma_go), it takes the Z80 bus via BUSRQ/BUSAK and copies LEN bytes of object attributes from the upper VRAM bank into the object line buffer.
- It then hands the bus back and flips the double-buffer select seen by the object renderer.
- It sits between jtpang_main (bus request, VRAM read port) and the object video block.

Parameters:
- LEN, 512: bytes copied per transfer; power of two, 2..4096.
- SRC_BASE, 12'h000: first VRAM byte address copied (within the 4 kB window).
- AW, 9: buffer address width; must satisfy 2**AW >= LEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  CPU clock enable; gates bus-request handshake sampling
- dma_go  in  1  level, high for the whole I/O cycle of a port-6 access
- busak_n  in  1  Z80 bus acknowledge, active low
- busrq_n  out  1  Z80 bus request, active low
- vram_addr  out  12  VRAM read address during the copy
- vram_cs  out  1  VRAM read strobe owned by DMA
- vram_msb  out  1  forces the upper VRAM bank while vram_cs is high
- vram_dout  in  8  VRAM read data, valid 1 clk after vram_cs/vram_addr
- buf_addr  out  AW  object buffer write address
- buf_din  out  8  object buffer write data
- buf_we  out  1  object buffer write strobe, one clk per byte
- buf_sel  out  1  buffer half being written; renderer reads ~buf_sel
- busy  out  1  high from request until bus released

Behaviour:
- Reset (rst_n=0, async): state IDLE, busrq_n=1, vram_cs=0, vram_msb=0, buf_we=0, buf_addr=0, buf_din=0, vram_addr=SRC_BASE, buf_sel=0, busy=0, pending=0, byte counter=0. A reset mid-transfer abandons it; a partial buffer is left as is and buf_sel does not flip.
- Trigger: rising edge of dma_go, registered on clk, sets pending. A level held high does not retrigger.
- FSM:
  - IDLE: if pending, clear pending, go to REQ, busy=1.
  - REQ: busrq_n=0. On a cen cycle with busak_n=0, go to COPY, counter=0.
  - COPY: each clk, vram_cs=1, vram_msb=1, vram_addr=SRC_BASE+counter (mod 4096). Data returns one clk later; the next clk sets buf_we=1, buf_addr=counter_d, buf_din=vram_dout. This is pipelined: one byte per clk, so LEN+1 clks from the first vram_cs to the last buf_we. After the address for counter=LEN-1 is issued, go to FLUSH.
  - FLUSH: one clk for the final write; vram_cs=0; toggle buf_sel; go to REL.
  - REL: busrq_n=1. On a cen cycle with busak_n=1, go to IDLE, busy=0.
- Simultaneous events: a dma_go edge while busy sets pending; exactly one further transfer runs after return to IDLE. Additional edges while pending is already set are merged.
- Handshake: busak_n is ignored outside REQ/REL. If busak_n deasserts during COPY (protocol violation), the copy completes anyway.
- Bus and strobes:
  - busrq_n never toggles within COPY/FLUSH.
  - vram_cs and buf_we are never high in IDLE, REQ or REL.
- Address wrap: the source address wraps modulo 4096. buf_addr covers 0..LEN-1 exactly once per transfer, ascending.
- Output timing: all outputs are registered except vram_msb, which equals vram_cs.

Test Plan:
- Basic copy: after reset, preload upper VRAM bytes at SRC_BASE+i with i[7:0]^8'h5A. Pulse dma_go high for 4 clks, and have busak_n follow busrq_n 3 cen cycles later.
  -> 512 buf_we pulses; buffer[i]=i[7:0]^8'h5A; buf_sel goes 0->1; busrq_n returns high; busy falls after busak_n=1.
- Held trigger: dma_go held high for 2000 clks.
  -> exactly one transfer; buf_sel toggles once.
- Re-trigger while busy: a second dma_go pulse during COPY, then a third during COPY.
  -> exactly two transfers in total; buf_sel ends at 0.
- Delayed acknowledge: busak_n is held high for 100 cen cycles in REQ.
  -> no vram_cs or buf_we until busak_n=0; first vram_cs on the clk after the acknowledge sample.
- Wrap: SRC_BASE=12'hF00, LEN=512.
  -> vram_addr sequence F00..FFF, then 000..0FF; buf_addr 0..511.
- Async reset: rst_n pulsed low at byte 200.
  -> busrq_n=1, buf_we=0 immediately; buf_sel stays 0; no further writes until a new dma_go.
